bcd_digit_entry_ctrl: RTL and testbench

Sequences entry of four BCD digits from the 4-bit switch bank into the four 7-segment displays (HEX0..HEX3) under control of one push-button. Provides a 2-flop synchronizer, a debounce FSM, single-event-per-press detection and a wrapping write pointer. Rejects non-decimal switch codes with a sticky error flag. The current cursor digit blinks. Sits between the raw board I/O (KEY, SW) and the HEX outputs in the top level.

---
 rtl/bcd_digit_entry_ctrl_if.sv | 37 +++
 rtl/bcd_digit_entry_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_bcd_digit_entry_ctrl.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/bcd_digit_entry_ctrl_if.sv
// Board-side bundle for the BCD digit entry controller:
// raw key/switch inputs in, segment drives and status out.
interface bcd_digit_entry_ctrl_if;
  logic       key_n;
  logic [3:0] sw;
  logic [6:0] hex0;
  logic [6:0] hex1;
  logic [6:0] hex2;
  logic [6:0] hex3;
  logic [1:0] digit_ptr;
  logic       err;
  logic       commit_pulse;

  modport master (
    output key_n,
    output sw,
    input  hex0,
    input  hex1,
    input  hex2,
    input  hex3,
    input  digit_ptr,
    input  err,
    input  commit_pulse
  );

  modport slave (
    input  key_n,
    input  sw,
    output hex0,
    output hex1,
    output hex2,
    output hex3,
    output digit_ptr,
    output err,
    output commit_pulse
  );
endinterface

// File: rtl/bcd_digit_entry_ctrl.sv
// Four-digit BCD entry: sync + debounce one key, write the
// switch value into a wrapping digit slot, blink the cursor.
module bcd_digit_entry_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1250000,
  parameter int BLINK_CYCLES    = 31250000
) (
  input logic                   CLOCK_125_p,
  input logic                   rst,
  bcd_digit_entry_ctrl_if.slave bus
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int BW = $clog2(BLINK_CYCLES);
  localparam logic [DW-1:0] DEB_LAST =
    DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [BW-1:0] BLK_LAST =
    BW'(BLINK_CYCLES - 1);

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } db_state_t;

  logic       key_s1;
  logic       key_s2;
  logic [3:0] sw_s1;
  logic [3:0] sw_s2;

  always_ff @(posedge CLOCK_125_p or posedge rst) begin
    if (rst) begin
      key_s1 <= 1'b1;
      key_s2 <= 1'b1;
      sw_s1  <= 4'd0;
      sw_s2  <= 4'd0;
    end else begin
      key_s1 <= bus.key_n;
      key_s2 <= key_s1;
      sw_s1  <= bus.sw;
      sw_s2  <= sw_s1;
    end
  end

  db_state_t       state;
  db_state_t       state_nxt;
  logic [DW-1:0]   db_cnt;
  logic [DW-1:0]   db_cnt_nxt;
  logic            press_evt;

  always_ff @(posedge CLOCK_125_p or posedge rst) begin
    if (rst) begin
      state  <= RELEASED;
      db_cnt <= '0;
    end else begin
      state  <= state_nxt;
      db_cnt <= db_cnt_nxt;
    end
  end

  // Counter stays at zero outside the wait states and on
  // every transition, so each wait starts a fresh count.
  always_comb begin
    state_nxt  = state;
    db_cnt_nxt = '0;
    press_evt  = 1'b0;
    unique case (state)
      RELEASED: begin
        if (!key_s2) state_nxt = PRESS_WAIT;
      end
      PRESS_WAIT: begin
        if (key_s2) begin
          state_nxt = RELEASED;
        end else if (db_cnt == DEB_LAST) begin
          state_nxt = PRESSED;
          press_evt = 1'b1;
        end else begin
          db_cnt_nxt = db_cnt + DW'(1);
        end
      end
      PRESSED: begin
        if (key_s2) state_nxt = RELEASE_WAIT;
      end
      RELEASE_WAIT: begin
        if (!key_s2) begin
          state_nxt = PRESSED;
        end else if (db_cnt == DEB_LAST) begin
          state_nxt = RELEASED;
        end else begin
          db_cnt_nxt = db_cnt + DW'(1);
        end
      end
      default: state_nxt = RELEASED;
    endcase
  end

  logic             sw_ok;
  logic             commit;
  logic [3:0][3:0]  dig_val;
  logic [3:0]       dig_vld;
  logic [1:0]       ptr_q;
  logic             err_q;
  logic             commit_q;

  assign sw_ok  = (sw_s2 <= 4'd9);
  assign commit = press_evt & sw_ok;

  always_ff @(posedge CLOCK_125_p or posedge rst) begin
    if (rst) begin
      dig_val  <= '0;
      dig_vld  <= '0;
      ptr_q    <= 2'd0;
      err_q    <= 1'b0;
      commit_q <= 1'b0;
    end else begin
      commit_q <= commit;
      if (press_evt) begin
        if (sw_ok) begin
          dig_val[ptr_q] <= sw_s2;
          dig_vld[ptr_q] <= 1'b1;
          ptr_q          <= ptr_q + 2'd1;
          err_q          <= 1'b0;
        end else begin
          err_q <= 1'b1;
        end
      end
    end
  end

  logic [BW-1:0] blink_cnt;
  logic          blink_on;

  // A commit restarts the phase so the new cursor is visible.
  always_ff @(posedge CLOCK_125_p or posedge rst) begin
    if (rst) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (commit) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (blink_cnt == BLK_LAST) begin
      blink_cnt <= '0;
      blink_on  <= ~blink_on;
    end else begin
      blink_cnt <= blink_cnt + BW'(1);
    end
  end

  function automatic logic [6:0] seg7(
    input logic [3:0] v
  );
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  logic [3:0][6:0] hex_w;
  logic [3:0]      show;

  always_comb begin
    hex_w = '1;
    show  = '0;
    for (int i = 0; i < 4; i++) begin
      show[i] = dig_vld[i] &
                (blink_on | (ptr_q != 2'(i)));
      if (show[i]) hex_w[i] = seg7(dig_val[i]);
    end
  end

  assign bus.hex0         = hex_w[0];
  assign bus.hex1         = hex_w[1];
  assign bus.hex2         = hex_w[2];
  assign bus.hex3         = hex_w[3];
  assign bus.digit_ptr    = ptr_q;
  assign bus.err          = err_q;
  assign bus.commit_pulse = commit_q;

endmodule

// File: tb/tb_bcd_digit_entry_ctrl.sv
// Directed bench for bcd_digit_entry_ctrl with a cycle-level
// run-length reference model checked every cycle.
module tb_bcd_digit_entry_ctrl;

  localparam int DEB = 4;
  localparam int BLK = 8;
  localparam logic [6:0] BLANK = 7'h7F;
  localparam logic [6:0] SEG [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000
  };
  localparam logic [3:0] FIRST4 [4] = '{
    4'd1, 4'd5, 4'd9, 4'd5
  };

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bcd_digit_entry_ctrl_if bus();

  bcd_digit_entry_ctrl #(
    .DEBOUNCE_CYCLES (DEB),
    .BLINK_CYCLES    (BLK)
  ) dut (
    .CLOCK_125_p (clk),
    .rst         (rst),
    .bus         (bus.slave)
  );

  int checks = 0;
  int passed = 0;

  task automatic chk(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h t=%0t",
                  name, act, exp, $time);
  endtask

  // Reference model: the key is accepted at a new level after
  // DEB+1 consecutive synchronized samples at that level.
  logic       m_k1, m_k2, m_ku;
  logic [3:0] m_w1, m_w2, m_su;
  logic       m_lvl;
  int         m_run;
  logic       m_ev;
  logic [3:0] m_dig [4];
  logic [3:0] m_vld;
  logic [1:0] m_ptr;
  logic       m_err;
  logic       m_commit;
  int         m_age;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_k1 = 1'b1; m_k2 = 1'b1;
      m_w1 = 4'd0; m_w2 = 4'd0;
      m_lvl = 1'b1; m_run = 0;
      for (int i = 0; i < 4; i++) m_dig[i] = 4'd0;
      m_vld = '0; m_ptr = 2'd0;
      m_err = 1'b0; m_commit = 1'b0;
      m_age = 0;
    end else begin
      m_ku = m_k2; m_su = m_w2;
      m_k2 = m_k1; m_k1 = bus.key_n;
      m_w2 = m_w1; m_w1 = bus.sw;
      m_ev = 1'b0;
      if (m_ku != m_lvl) begin
        m_run++;
        if (m_run == DEB + 1) begin
          m_lvl = m_ku;
          m_run = 0;
          m_ev  = !m_ku;
        end
      end else begin
        m_run = 0;
      end
      m_age++;
      m_commit = 1'b0;
      if (m_ev) begin
        if (m_su <= 4'd9) begin
          m_dig[m_ptr] = m_su;
          m_vld[m_ptr] = 1'b1;
          m_ptr = m_ptr + 2'd1;
          m_err = 1'b0;
          m_commit = 1'b1;
          m_age = 0;
        end else begin
          m_err = 1'b1;
        end
      end
    end
  end

  function automatic logic [6:0] exp_hex(input int i);
    if (!m_vld[i]) return BLANK;
    if (i == int'(m_ptr) && ((m_age / BLK) % 2) == 1)
      return BLANK;
    return SEG[m_dig[i]];
  endfunction

  always @(posedge clk) begin
    #3;
    chk("hex0", {25'd0, bus.hex0}, {25'd0, exp_hex(0)});
    chk("hex1", {25'd0, bus.hex1}, {25'd0, exp_hex(1)});
    chk("hex2", {25'd0, bus.hex2}, {25'd0, exp_hex(2)});
    chk("hex3", {25'd0, bus.hex3}, {25'd0, exp_hex(3)});
    chk("digit_ptr", {30'd0, bus.digit_ptr}, {30'd0, m_ptr});
    chk("err", {31'd0, bus.err}, {31'd0, m_err});
    chk("commit_pulse", {31'd0, bus.commit_pulse},
        {31'd0, m_commit});
  end

  task automatic run_cycles(input int n, output int np);
    np = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (bus.commit_pulse) np++;
    end
  endtask

  // lat = edges after the first edge that samples key_n low.
  task automatic press(
    input  logic [3:0] v,
    input  int         hold,
    input  int         rel,
    output int         lat,
    output int         np
  );
    bus.sw = v;
    bus.key_n = 1'b0;
    lat = -1;
    np = 0;
    for (int i = 1; i <= hold; i++) begin
      @(negedge clk);
      if (bus.commit_pulse) begin
        np++;
        if (lat < 0) lat = i - 1;
      end
    end
    bus.key_n = 1'b1;
    for (int i = 0; i < rel; i++) begin
      @(negedge clk);
      if (bus.commit_pulse) np++;
    end
  endtask

  int lat, np, n2, bad, bad2, seen;

  initial begin
    bus.key_n = 1'b1;
    bus.sw = 4'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_hex0", {25'd0, bus.hex0}, {25'd0, BLANK});
    chk("rst_hex1", {25'd0, bus.hex1}, {25'd0, BLANK});
    chk("rst_hex2", {25'd0, bus.hex2}, {25'd0, BLANK});
    chk("rst_hex3", {25'd0, bus.hex3}, {25'd0, BLANK});
    chk("rst_ptr", {30'd0, bus.digit_ptr}, 32'd0);
    chk("rst_err", {31'd0, bus.err}, 32'd0);

    bus.key_n = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    bus.key_n = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    run_cycles(12, np);
    chk("midpw_rst_pulses", np, 0);
    chk("midpw_rst_hex0", {25'd0, bus.hex0}, {25'd0, BLANK});
    chk("midpw_rst_ptr", {30'd0, bus.digit_ptr}, 32'd0);

    for (int p = 0; p < 4; p++) begin
      press(FIRST4[p], 10, 13, lat, np);
      chk("press_latency", lat, 6);
      chk("press_pulses", np, 1);
    end
    chk("four_hex0", {25'd0, bus.hex0}, 32'h79);
    chk("four_hex1", {25'd0, bus.hex1}, 32'h12);
    chk("four_hex2", {25'd0, bus.hex2}, 32'h10);
    chk("four_hex3", {25'd0, bus.hex3}, 32'h12);
    chk("four_ptr", {30'd0, bus.digit_ptr}, 32'd0);

    press(4'd7, 10, 13, lat, np);
    chk("wrap_pulses", np, 1);
    chk("wrap_hex0", {25'd0, bus.hex0}, 32'h78);
    chk("wrap_hex1", {25'd0, bus.hex1}, 32'h12);
    chk("wrap_hex2", {25'd0, bus.hex2}, 32'h10);
    chk("wrap_ptr", {30'd0, bus.digit_ptr}, 32'd1);

    press(4'd12, 10, 13, lat, np);
    chk("bad_code_pulses", np, 0);
    chk("bad_code_err", {31'd0, bus.err}, 32'd1);
    chk("bad_code_ptr", {30'd0, bus.digit_ptr}, 32'd1);
    chk("bad_code_hex0", {25'd0, bus.hex0}, 32'h78);
    run_cycles(20, np);
    chk("err_sticky", {31'd0, bus.err}, 32'd1);

    press(4'd3, 10, 13, lat, np);
    chk("recover_pulses", np, 1);
    chk("recover_err", {31'd0, bus.err}, 32'd0);
    chk("recover_hex1", {25'd0, bus.hex1}, 32'h30);
    chk("recover_ptr", {30'd0, bus.digit_ptr}, 32'd2);

    bus.sw = 4'd2;
    bus.key_n = 1'b0; run_cycles(3, np);
    bus.key_n = 1'b1; run_cycles(2, n2); np += n2;
    bus.key_n = 1'b0; run_cycles(2, n2); np += n2;
    bus.key_n = 1'b1; run_cycles(15, n2); np += n2;
    chk("bounce_pulses", np, 0);

    press(4'd8, 100, 13, lat, np);
    chk("long_hold_pulses", np, 1);
    chk("long_hold_latency", lat, 6);
    chk("long_hold_hex2", {25'd0, bus.hex2}, 32'h00);
    chk("long_hold_ptr", {30'd0, bus.digit_ptr}, 32'd3);

    bus.sw = 4'd6;
    bus.key_n = 1'b0; run_cycles(20, np);
    bus.key_n = 1'b1; run_cycles(2, n2); np += n2;
    bus.key_n = 1'b0; run_cycles(20, n2); np += n2;
    bus.key_n = 1'b1; run_cycles(13, n2); np += n2;
    chk("short_release_pulses", np, 1);
    chk("short_release_hex3", {25'd0, bus.hex3}, 32'h02);
    chk("short_release_ptr", {30'd0, bus.digit_ptr}, 32'd0);

    bus.sw = 4'd4;
    bus.key_n = 1'b0;
    seen = 0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      @(negedge clk);
      if (bus.commit_pulse) seen = 1;
    end
    bus.key_n = 1'b1;
    chk("blink_commit_seen", seen, 1);
    bad = 0;
    bad2 = 0;
    if (seen == 1) begin
      for (int i = 0; i < 32; i++) begin
        if (i > 0) @(negedge clk);
        if (bus.hex1 !== (((i / 8) % 2 == 0) ? 7'h30 : BLANK))
          bad++;
        if (bus.hex0 !== 7'h19) bad2++;
      end
    end
    chk("blink_cursor_errors", bad, 0);
    chk("blink_steady_errors", bad2, 0);

    bus.sw = 4'd2;
    bus.key_n = 1'b0;
    rst = 1'b1;
    run_cycles(2, np);
    rst = 1'b0;
    run_cycles(20, np);
    chk("rst_held_key_pulses", np, 1);
    chk("rst_held_key_hex0", {25'd0, bus.hex0}, 32'h24);
    chk("rst_held_key_ptr", {30'd0, bus.digit_ptr}, 32'd1);
    bus.key_n = 1'b1;
    run_cycles(15, np);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
